// File: rtl/tape_command_driver.sv
// Initiator for the 4-bit-symbol tape: one opcode at a time, strobe, wait for tape_available.
// Optional macro TAPE_DRV_SAT_EN: add at 4'hF / sub at 4'h0 leave the cell unchanged instead of wrapping.
module tape_command_driver #(
  parameter int ADDR_MAX = 127,
  parameter int TIMEOUT  = 255
) (
  input  logic       working_clock,
  input  logic       reset_n,
  input  logic [3:0] cmd_op,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] in_data,
  output logic [3:0] out_data,
  output logic       out_valid,
  output logic       cell_zero,
  output logic       bound_err,
  output logic       timeout_err,
  output logic [3:0] tape_new_symbol,
  output logic       tape_set_symbol,
  output logic       tape_move,
  output logic       tape_move_dir,
  output logic       roll_back,
  output logic       tape_delete,
  input  logic [3:0] tape_symbol,
  input  logic       tape_available,
  input  logic [6:0] tape_address
);

  localparam int         CNT_W    = $clog2(TIMEOUT + 2);
  localparam logic [6:0] ADDR_TOP = 7'(ADDR_MAX);

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [3:0] OP_HAT = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MOL = 4'h3;
  localparam logic [3:0] OP_MOR = 4'h4;
  localparam logic [3:0] OP_INP = 4'h5;
  localparam logic [3:0] OP_OUP = 4'h6;
  localparam logic [3:0] OP_LOL = 4'h7;
  localparam logic [3:0] OP_LOR = 4'h8;
  localparam logic [3:0] OP_CEO = 4'h9;
  localparam logic [3:0] OP_ZER = 4'hA;
  localparam logic [3:0] OP_PAS = 4'hB;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_new_symbol;
  logic [3:0]       r_out_data;
  logic             r_set, r_move, r_dir, r_roll, r_del;
  logic             r_out_valid, r_bound, r_timeout, r_cell_zero;

  logic       w_set, w_move, w_dir, w_roll, w_del, w_bound, w_oup, w_issue;
  logic [3:0] w_new;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_set   = 1'b0;
    w_move  = 1'b0;
    w_dir   = 1'b0;
    w_roll  = 1'b0;
    w_del   = 1'b0;
    w_bound = 1'b0;
    w_oup   = 1'b0;
    w_new   = tape_symbol;
    case (cmd_op)
      OP_ADD: begin
        w_new = tape_symbol + 4'd1;
`ifdef TAPE_DRV_SAT_EN
        w_set = (tape_symbol != 4'hF);
`else
        w_set = 1'b1;
`endif
      end
      OP_SUB: begin
        w_new = tape_symbol - 4'd1;
`ifdef TAPE_DRV_SAT_EN
        w_set = (tape_symbol != 4'h0);
`else
        w_set = 1'b1;
`endif
      end
      OP_ZER: begin
        w_set = 1'b1;
        w_new = 4'h0;
      end
      OP_INP: begin
        w_set = 1'b1;
        w_new = in_data;
      end
      OP_MOL: begin
        w_bound = (tape_address == 7'd0);
        w_move  = !w_bound;
      end
      OP_MOR: begin
        w_bound = (tape_address == ADDR_TOP);
        w_move  = !w_bound;
        w_dir   = 1'b1;
      end
      OP_CEO: w_roll = (tape_address != 7'd0);
      OP_HAT: w_del  = 1'b1;
      OP_OUP: w_oup  = 1'b1;
      OP_LOL, OP_LOR, OP_PAS: ;
      default: ;
    endcase
  end

  assign w_issue = w_set | w_move | w_roll | w_del;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge working_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_BOOT;
      r_cnt        <= '0;
      r_new_symbol <= 4'h0;
      r_out_data   <= 4'h0;
      r_set        <= 1'b0;
      r_move       <= 1'b0;
      r_dir        <= 1'b0;
      r_roll       <= 1'b0;
      r_del        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_bound      <= 1'b0;
      r_timeout    <= 1'b0;
      r_cell_zero  <= 1'b0;
    end else begin
      r_set       <= 1'b0;
      r_move      <= 1'b0;
      r_roll      <= 1'b0;
      r_del       <= 1'b0;
      r_out_valid <= 1'b0;
      r_bound     <= 1'b0;
      case (r_state)
        S_BOOT: if (tape_available) r_state <= S_IDLE;
        S_IDLE: if (cmd_valid) begin
          // Strobes and payload are registered at acceptance so they appear for exactly the ISSUE cycle.
          r_set        <= w_set;
          r_move       <= w_move;
          r_roll       <= w_roll;
          r_del        <= w_del;
          r_dir        <= w_dir;
          r_new_symbol <= w_new;
          r_bound      <= w_bound;
          if (w_oup) begin
            r_out_data  <= tape_symbol;
            r_out_valid <= 1'b1;
          end
          r_state <= w_issue ? S_ISSUE : S_DONE;
        end
        S_ISSUE:  r_state <= S_SETTLE;
        S_SETTLE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (tape_available) begin
            r_state <= S_DONE;
          end else if (r_cnt >= CNT_W'(TIMEOUT)) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_cell_zero <= (tape_symbol == 4'h0);
          r_state     <= S_IDLE;
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign cmd_ready       = (r_state == S_IDLE);
  assign out_data        = r_out_data;
  assign out_valid       = r_out_valid;
  assign cell_zero       = r_cell_zero;
  assign bound_err       = r_bound;
  assign timeout_err     = r_timeout;
  assign tape_new_symbol = r_new_symbol;
  assign tape_set_symbol = r_set;
  assign tape_move       = r_move;
  assign tape_move_dir   = r_dir;
  assign roll_back       = r_roll;
  assign tape_delete     = r_del;

endmodule
